// File: rtl/seq_multiplier_pkg.sv
// ============================================================================
// Module : seq_multiplier_pkg
// Brief  : Shared defaults, FSM state encoding and op codes for seq_multiplier
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_multiplier_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2,
        S_FIX  = 2'd3
    } mul_state_e;

    // EX-stage funct codes that select this unit as the HI/LO source
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;

endpackage

`default_nettype wire

// File: rtl/seq_multiplier_full_adder.sv
// ============================================================================
// Module : seq_multiplier_full_adder
// Brief  : WIDTH-bit adder with carry in/out; the multiplier's only adder path
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_multiplier_full_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module : seq_multiplier
// Brief  : Iterative shift-and-add multiplier, one partial product per cycle.
//          Optional signed support under macro MUL_SIGNED_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cancel_i,
    input  logic             signed_op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic [WIDTH-1:0] prod_lo_o
);

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

    logic [WIDTH-1:0] w_add_a, w_add_b, w_sum;
    logic             w_add_cin, w_cout;
    logic [WIDTH-1:0] w_step_hi, w_step_lo;
    logic [WIDTH-1:0] w_op_a, w_op_b;

`ifdef MUL_SIGNED_EN
    logic             neg_q, neg_d;
    logic             w_neg_a, w_neg_b;
    logic [WIDTH-1:0] w_fix_hi;

    assign w_neg_a = signed_op_i & a_i[WIDTH-1];
    assign w_neg_b = signed_op_i & b_i[WIDTH-1];
    assign w_op_a  = w_neg_a ? (~a_i + {{(WIDTH-1){1'b0}}, 1'b1}) : a_i;
    assign w_op_b  = w_neg_b ? (~b_i + {{(WIDTH-1){1'b0}}, 1'b1}) : b_i;
    // The low-word carry of ~lo+1 ripples into the inverted high word
    assign w_fix_hi = ~acc_hi_q + {{(WIDTH-1){1'b0}}, w_cout};
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op_i;
    assign w_op_a = a_i;
    assign w_op_b = b_i;
`endif

    always_comb begin
        w_add_a   = acc_hi_q;
        w_add_b   = acc_lo_q[0] ? mcand_q : '0;
        w_add_cin = 1'b0;
`ifdef MUL_SIGNED_EN
        if (state_q == S_FIX) begin
            w_add_a   = ~acc_lo_q;
            w_add_b   = '0;
            w_add_cin = 1'b1;
        end
`endif
    end

    seq_multiplier_full_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (w_add_a),
        .b_i    (w_add_b),
        .cin_i  (w_add_cin),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    // Carry becomes the new MSB of the high word as the pair shifts right
    assign w_step_hi = {w_cout, w_sum[WIDTH-1:1]};
    assign w_step_lo = {w_sum[0], acc_lo_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
`ifdef MUL_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (start_i && !(state_q == S_DONE && cancel_i)) begin
                    state_d  = S_BUSY;
                    mcand_d  = w_op_a;
                    acc_hi_d = '0;
                    acc_lo_d = w_op_b;
                    cnt_d    = '0;
`ifdef MUL_SIGNED_EN
                    neg_d    = w_neg_a ^ w_neg_b;
`endif
                end
            end
            S_BUSY: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_hi_d = w_step_hi;
                    acc_lo_d = w_step_lo;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == C_LAST_CNT) begin
`ifdef MUL_SIGNED_EN
                        if (neg_q) begin
                            state_d = S_FIX;
                        end else begin
                            state_d   = S_DONE;
                            prod_hi_d = w_step_hi;
                            prod_lo_d = w_step_lo;
                        end
`else
                        state_d   = S_DONE;
                        prod_hi_d = w_step_hi;
                        prod_lo_d = w_step_lo;
`endif
                    end
                end
            end
`ifdef MUL_SIGNED_EN
            S_FIX: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_DONE;
                    acc_hi_d  = w_fix_hi;
                    acc_lo_d  = w_sum;
                    prod_hi_d = w_fix_hi;
                    prod_lo_d = w_sum;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
`ifdef MUL_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
`ifdef MUL_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign busy_o    = (state_q == S_BUSY) || (state_q == S_FIX);
    assign done_o    = (state_q == S_DONE);
    assign prod_hi_o = prod_hi_q;
    assign prod_lo_o = prod_lo_q;

endmodule

`default_nettype wire
